// File: rtl/cnt_axil_arbiter_if.sv
// AXI4-Lite link between the arbiter (master) and the count_ip S00_AXI register slave.
// Latency: wires only.
// Backpressure: standard per-channel valid/ready.
interface cnt_axil_arbiter_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/cnt_axil_arbiter.sv
// Two-requester round-robin AXI4-Lite master sharing one count_ip register slave.
// Latency: accept T, AW/W or AR at T+1, response pulse at T+3 with a zero-wait slave.
// Backpressure: rq_ready only in IDLE for the arbitration winner; responses are never stalled.
module cnt_axil_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32   // count_ip registers are 32 bits wide; other widths unsupported
) (
   input  logic                        ACLK,
   input  logic                        ARESETN,
   input  logic [1:0]                  rq_valid,
   output logic [1:0]                  rq_ready,
   input  logic [1:0]                  rq_write,
   input  logic [2*ADDR_WIDTH-1:0]     rq_addr,
   input  logic [2*DATA_WIDTH-1:0]     rq_wdata,
   input  logic [2*DATA_WIDTH/8-1:0]   rq_wstrb,
   output logic [1:0]                  rs_valid,
   output logic [DATA_WIDTH-1:0]       rs_rdata,
   output logic [1:0]                  rs_resp,
   output logic                        busy,
   cnt_axil_arbiter_if.master          m_axi
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] WR   = 3'd1;
   localparam logic [2:0] WB   = 3'd2;
   localparam logic [2:0] RD   = 3'd3;
   localparam logic [2:0] RR   = 3'd4;

   logic [2:0]            state;
   logic                  last_grant;
   logic                  owner;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  aw_done;
   logic                  w_done;

   logic                  win;
   logic                  accept;
   logic                  sel_write;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [STRB_WIDTH-1:0] sel_wstrb;
   logic                  aw_hs;
   logic                  w_hs;

   // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
   always_comb begin
      win      = rq_valid[1];
      if (rq_valid == 2'b11) begin
         win = ~last_grant;
      end
      rq_ready = 2'b00;
      if (state == IDLE && rq_valid != 2'b00) begin
         rq_ready = win ? 2'b10 : 2'b01;
      end
      accept    = (rq_ready != 2'b00);
      sel_write = win ? rq_write[1] : rq_write[0];
      sel_addr  = win ? rq_addr[ADDR_WIDTH +: ADDR_WIDTH]   : rq_addr[0 +: ADDR_WIDTH];
      sel_wdata = win ? rq_wdata[DATA_WIDTH +: DATA_WIDTH]  : rq_wdata[0 +: DATA_WIDTH];
      sel_wstrb = win ? rq_wstrb[STRB_WIDTH +: STRB_WIDTH]  : rq_wstrb[0 +: STRB_WIDTH];
   end

   // AXI channel drives come straight from state so they drop the cycle after their handshake.
   assign m_axi.awaddr  = addr_q;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awvalid = (state == WR) && !aw_done;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = wstrb_q;
   assign m_axi.wvalid  = (state == WR) && !w_done;
   assign m_axi.bready  = (state == WB);
   assign m_axi.araddr  = addr_q;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.arvalid = (state == RD);
   assign m_axi.rready  = (state == RR);

   assign aw_hs = m_axi.awvalid && m_axi.awready;
   assign w_hs  = m_axi.wvalid && m_axi.wready;
   assign busy  = (state != IDLE);

   // Transaction FSM: latch the winning command, then walk the AXI channels one at a time.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  owner      <= win;
                  last_grant <= win;
                  addr_q     <= sel_addr;
                  wdata_q    <= sel_wdata;
                  wstrb_q    <= sel_wstrb;
                  aw_done    <= 1'b0;
                  w_done     <= 1'b0;
                  state      <= sel_write ? WR : RD;
               end
            end
            WR: begin
               // AW and W may complete in any order or together; wait for both.
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  state <= WB;
               end
            end
            WB: begin
               if (m_axi.bvalid) state <= IDLE;
            end
            RD: begin
               if (m_axi.arready) state <= RR;
            end
            RR: begin
               if (m_axi.rvalid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Registered one-cycle response pulse back to whichever requester owns the transaction.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rs_valid <= 2'b00;
         rs_rdata <= '0;
         rs_resp  <= 2'b00;
      end else begin
         rs_valid <= 2'b00;
         if (state == WB && m_axi.bvalid) begin
            rs_valid <= owner ? 2'b10 : 2'b01;
            rs_rdata <= '0;
            rs_resp  <= m_axi.bresp;
         end else if (state == RR && m_axi.rvalid) begin
            rs_valid <= owner ? 2'b10 : 2'b01;
            rs_rdata <= m_axi.rdata;
            rs_resp  <= m_axi.rresp;
         end
      end
   end
endmodule
